// File: rtl/fetch_decode_unit_if.sv
// Shared front-end types and the IR side of the issue-queue enqueue link.
// IQ_2_IR: ld_iq/control_word/rvfi from IR (master), issue_q_full_n from IQ (slave).
package tomasula_types;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SLL = 4'd1,
        OP_CMP = 4'd2,
        OP_XOR = 4'd3,
        OP_SHR = 4'd4,
        OP_OR  = 4'd5,
        OP_AND = 4'd6,
        OP_BR  = 4'd7,
        OP_LD  = 4'd8,
        OP_ST  = 4'd9
    } op_t;

    typedef struct packed {
        op_t         op;
        logic [31:0] og_instr;
        logic [31:0] og_pc;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        funct7;
        logic [4:0]  src1_reg;
        logic        src1_valid;
        logic [4:0]  src2_reg;
        logic        src2_valid;
        logic [31:0] src2_data;
    } ctl_word;
endpackage

package rv32i_types;
    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] inst;
        logic        trap;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } rvfi_word;
endpackage

interface IQ_2_IR;
    import tomasula_types::*;
    import rv32i_types::*;

    logic     ld_iq;
    ctl_word  control_word;
    rvfi_word rvfi;
    logic     issue_q_full_n;

    modport master (
        output ld_iq, control_word, rvfi,
        input  issue_q_full_n
    );
    modport slave (
        input  ld_iq, control_word, rvfi,
        output issue_q_full_n
    );
endinterface

// File: rtl/fetch_decode_unit.sv
// In-order RV32I fetch + decode, one instruction in flight, enqueues into the IQ.
// Ports: clk_i/reset_n_i, imem_* fetch port, flush/flush_pc redirect, iq_ack, iq_ir_itf.
module fetch_decode_unit
    import tomasula_types::*;
    import rv32i_types::*;
#(
    parameter logic [31:0] PC_RESET = 32'h6000_0000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        iq_ack,
    IQ_2_IR.master      iq_ir_itf
);

    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] stale_addr;
    logic        ld_q;
    ctl_word     cw_q, cw_d;
    rvfi_word    rv_q, rv_d;

    // Reset gates the request so the port sees no read while held in reset.
    assign imem_read    = reset_n_i && (state != HOLD);
    assign imem_address = (state == DRAIN) ? stale_addr : pc;

    assign iq_ir_itf.ld_iq        = ld_q;
    assign iq_ir_itf.control_word = cw_q;
    assign iq_ir_itf.rvfi         = rv_q;

    logic [6:0]  opc;
    logic [31:0] imm_i, imm_u, imm_j;
    logic        is_op, is_opimm, is_load, is_store, is_branch;
    logic        is_jalr, is_jal, is_lui, is_auipc;

    assign opc   = imem_rdata[6:0];
    assign imm_i = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
    assign imm_u = {imem_rdata[31:12], 12'h000};
    assign imm_j = {{12{imem_rdata[31]}}, imem_rdata[19:12],
                    imem_rdata[20], imem_rdata[30:21], 1'b0};

    assign is_op     = (opc == 7'b0110011);
    assign is_opimm  = (opc == 7'b0010011);
    assign is_load   = (opc == 7'b0000011);
    assign is_store  = (opc == 7'b0100011);
    assign is_branch = (opc == 7'b1100011);
    assign is_jalr   = (opc == 7'b1100111);
    assign is_jal    = (opc == 7'b1101111);
    assign is_lui    = (opc == 7'b0110111);
    assign is_auipc  = (opc == 7'b0010111);

    // SLT/SLTU share a class and ADD/SUB, SRL/SRA are split by funct3/funct7.
    function automatic op_t alu_class(input logic [2:0] f3);
        op_t r;
        unique case (f3)
            3'b000:         r = OP_ADD;
            3'b001:         r = OP_SLL;
            3'b010, 3'b011: r = OP_CMP;
            3'b100:         r = OP_XOR;
            3'b101:         r = OP_SHR;
            3'b110:         r = OP_OR;
            default:        r = OP_AND;
        endcase
        return r;
    endfunction

    always_comb begin
        cw_d          = '0;
        cw_d.og_instr = imem_rdata;
        cw_d.og_pc    = pc;
        cw_d.pc       = pc + 32'd4;
        cw_d.rd       = imem_rdata[11:7];
        cw_d.funct3   = imem_rdata[14:12];
        cw_d.funct7   = imem_rdata[30];
        cw_d.src1_reg = imem_rdata[19:15];
        cw_d.op       = alu_class(imem_rdata[14:12]);
        unique case (1'b1)
            is_op: begin
                cw_d.src2_reg = imem_rdata[24:20];
            end
            is_opimm: begin
                cw_d.src2_valid = 1'b1;
                cw_d.src2_data  = imm_i;
            end
            is_load: begin
                cw_d.op         = OP_LD;
                cw_d.src2_valid = 1'b1;
                cw_d.src2_data  = imm_i;
            end
            is_store: begin
                cw_d.op       = OP_ST;
                cw_d.src2_reg = imem_rdata[24:20];
                cw_d.rd       = 5'd0;
            end
            is_branch: begin
                cw_d.op       = OP_BR;
                cw_d.src2_reg = imem_rdata[24:20];
                cw_d.rd       = 5'd0;
            end
            is_jalr: begin
                cw_d.op         = OP_BR;
                cw_d.src2_valid = 1'b1;
                cw_d.src2_data  = imm_i;
            end
            is_jal: begin
                cw_d.op         = OP_BR;
                cw_d.src1_valid = 1'b1;
                cw_d.src2_valid = 1'b1;
                cw_d.src2_data  = imm_j;
            end
            is_lui: begin
                cw_d.op         = OP_ADD;
                cw_d.src1_valid = 1'b1;
                cw_d.src2_valid = 1'b1;
                cw_d.src2_data  = imm_u;
            end
            is_auipc: begin
                cw_d.op         = OP_ADD;
                cw_d.src1_valid = 1'b1;
                cw_d.src2_valid = 1'b1;
                cw_d.src2_data  = pc + imm_u;
            end
            default: begin
                // Unknown opcode becomes addi x0,x0,0.
                cw_d.op         = OP_ADD;
                cw_d.rd         = 5'd0;
                cw_d.funct3     = 3'd0;
                cw_d.funct7     = 1'b0;
                cw_d.src1_reg   = 5'd0;
                cw_d.src1_valid = 1'b1;
                cw_d.src2_valid = 1'b1;
                cw_d.src2_data  = 32'd0;
            end
        endcase
    end

    always_comb begin
        rv_d          = '0;
        rv_d.inst     = imem_rdata;
        rv_d.pc_rdata = pc;
        rv_d.pc_wdata = pc + 32'd4;
        rv_d.rs1_addr = cw_d.src1_valid ? 5'd0 : cw_d.src1_reg;
        rv_d.rs2_addr = cw_d.src2_reg;
        rv_d.rd_addr  = cw_d.rd;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            stale_addr <= '0;
            ld_q       <= 1'b0;
            cw_q       <= '0;
            rv_q       <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (flush) begin
                        pc   <= flush_pc;
                        ld_q <= 1'b0;
                        if (!imem_resp) begin
                            stale_addr <= pc;
                            state      <= DRAIN;
                        end
                    end else if (imem_resp) begin
                        cw_q  <= cw_d;
                        rv_q  <= rv_d;
                        ld_q  <= 1'b1;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        pc    <= flush_pc;
                        ld_q  <= 1'b0;
                        state <= FETCH;
                    end else if (iq_ack) begin
                        pc    <= pc + 32'd4;
                        ld_q  <= 1'b0;
                        state <= FETCH;
                    end
                end
                default: begin
                    if (flush) begin
                        pc <= flush_pc;
                    end
                    if (imem_resp) begin
                        state <= FETCH;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: directed front-end scenarios then random traffic.
// Expected words are queued at response time and popped when ld_iq rises.
module tb_fetch_decode_unit;
    import tomasula_types::*;
    import rv32i_types::*;

    localparam logic [31:0] PC_RESET = 32'h6000_0000;

    typedef struct packed {
        ctl_word  c;
        rvfi_word r;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        imem_resp = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        iq_ack = 1'b0;

    IQ_2_IR iq ();

    fetch_decode_unit dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .iq_ack       (iq_ack),
        .iq_ir_itf    (iq)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference decode written straight from the instruction-format rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] ii, iu, ij;
        op_t         alu [0:7];
        alu = '{OP_ADD, OP_SLL, OP_CMP, OP_CMP, OP_XOR, OP_SHR, OP_OR, OP_AND};
        ii = 32'($signed(ins[31:20]));
        iu = ins & 32'hFFFF_F000;
        ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
        e = '0;
        e.c.og_instr = ins;
        e.c.og_pc    = pc;
        e.c.pc       = pc + 4;
        e.c.rd       = ins[11:7];
        e.c.funct3   = ins[14:12];
        e.c.funct7   = ins[30];
        e.c.src1_reg = ins[19:15];
        case (ins[6:0])
            7'h33: begin e.c.op = alu[ins[14:12]]; e.c.src2_reg = ins[24:20]; end
            7'h13: begin e.c.op = alu[ins[14:12]]; e.c.src2_valid = 1; e.c.src2_data = ii; end
            7'h03: begin e.c.op = OP_LD; e.c.src2_valid = 1; e.c.src2_data = ii; end
            7'h23: begin e.c.op = OP_ST; e.c.src2_reg = ins[24:20]; e.c.rd = 0; end
            7'h63: begin e.c.op = OP_BR; e.c.src2_reg = ins[24:20]; e.c.rd = 0; end
            7'h67: begin e.c.op = OP_BR; e.c.src2_valid = 1; e.c.src2_data = ii; end
            7'h6F: begin
                e.c.op = OP_BR; e.c.src1_valid = 1;
                e.c.src2_valid = 1; e.c.src2_data = ij;
            end
            7'h37: begin
                e.c.op = OP_ADD; e.c.src1_valid = 1;
                e.c.src2_valid = 1; e.c.src2_data = iu;
            end
            7'h17: begin
                e.c.op = OP_ADD; e.c.src1_valid = 1;
                e.c.src2_valid = 1; e.c.src2_data = pc + iu;
            end
            default: begin
                e.c.op = OP_ADD; e.c.rd = 0; e.c.funct3 = 0; e.c.funct7 = 0;
                e.c.src1_reg = 0; e.c.src1_valid = 1;
                e.c.src2_valid = 1; e.c.src2_data = 0;
            end
        endcase
        e.r.inst     = ins;
        e.r.pc_rdata = pc;
        e.r.pc_wdata = pc + 4;
        e.r.rs1_addr = e.c.src1_valid ? 5'd0 : e.c.src1_reg;
        e.r.rs2_addr = e.c.src2_reg;
        e.r.rd_addr  = e.c.rd;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  opcs [0:9];
        int          k;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                 7'h67, 7'h6F, 7'h37, 7'h17, 7'h0F};
        r = $urandom();
        k = $urandom_range(0, 10);
        if (k == 10) r[1:0] = 2'b00;
        else         r[6:0] = opcs[k];
        return r;
    endfunction

    // Monitor: each new presentation of ld_iq consumes one expected word.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (iq.ld_iq && !prev) begin
                chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("control_word", iq.control_word, e.c);
                    chk("rvfi", iq.rvfi, e.r);
                end
            end
            prev = iq.ld_iq;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic respond(input logic [31:0] ins, input bit push,
                           input logic [31:0] pc);
        imem_resp  = 1'b1;
        imem_rdata = ins;
        if (push) sb.push_back(model(ins, pc));
        @(negedge clk);
        imem_resp = 1'b0;
    endtask

    task automatic ack_one();
        iq_ack = 1'b1;
        @(negedge clk);
        iq_ack = 1'b0;
    endtask

    logic [31:0] exp_pc;
    bit          busy, stale, do_resp, do_flush, do_ack;
    int          wait_cnt;

    initial begin
        iq.issue_q_full_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_imem_read", imem_read, 0);
        chk("rst_ld_iq", iq.ld_iq, 0);
        chk("rst_control_word", iq.control_word, 0);
        chk("rst_rvfi", iq.rvfi, 0);

        reset_n = 1'b1;
        @(negedge clk);
        chk("first_read", imem_read, 1);
        chk("first_addr", imem_address, PC_RESET);
        @(negedge clk);
        respond(32'h0050_0093, 1, PC_RESET);
        chk("addi_ld_iq", iq.ld_iq, 1);
        chk("addi_src2_valid", iq.control_word.src2_valid, 1);
        chk("addi_src2_data", iq.control_word.src2_data, 5);
        chk("addi_rd", iq.control_word.rd, 1);
        chk("addi_pc", iq.control_word.pc, 32'h6000_0004);
        chk("hold_no_read", imem_read, 0);

        iq.issue_q_full_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_ld_iq", iq.ld_iq, 1);
            chk("bp_word", iq.control_word, model(32'h0050_0093, PC_RESET).c);
            chk("bp_no_read", imem_read, 0);
        end
        iq.issue_q_full_n = 1'b1;
        ack_one();
        chk("ack_ld_iq", iq.ld_iq, 0);
        chk("ack_read", imem_read, 1);
        chk("ack_addr", imem_address, 32'h6000_0004);

        flush    = 1'b1;
        flush_pc = 32'h6000_0100;
        @(negedge clk);
        flush = 1'b0;
        chk("drain_read", imem_read, 1);
        chk("drain_addr", imem_address, 32'h6000_0004);
        @(negedge clk);
        respond(32'h0010_0113, 0, 0);
        chk("drain_ld_iq", iq.ld_iq, 0);
        chk("redir_read", imem_read, 1);
        chk("redir_addr", imem_address, 32'h6000_0100);

        respond(32'h0020_A423, 1, 32'h6000_0100);
        chk("sw_ld_iq", iq.ld_iq, 1);
        chk("sw_op", iq.control_word.op, OP_ST);
        chk("sw_rd", iq.control_word.rd, 0);
        iq_ack   = 1'b1;
        flush    = 1'b1;
        flush_pc = 32'h6000_0200;
        @(negedge clk);
        iq_ack = 1'b0;
        flush  = 1'b0;
        chk("fa_ld_iq", iq.ld_iq, 0);
        chk("fa_addr", imem_address, 32'h6000_0200);

        respond(32'h0020_8863, 1, 32'h6000_0200);
        chk("beq_op", iq.control_word.op, OP_BR);
        chk("beq_rd", iq.control_word.rd, 0);
        chk("beq_src2_valid", iq.control_word.src2_valid, 0);
        ack_one();
        chk("beq_next_addr", imem_address, 32'h6000_0204);
        respond(32'h1234_51B7, 1, 32'h6000_0204);
        chk("lui_src2_data", iq.control_word.src2_data, 32'h1234_5000);
        chk("lui_src1_valid", iq.control_word.src1_valid, 1);
        chk("lui_rd", iq.control_word.rd, 3);

        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_ld_iq", iq.ld_iq, 0);
        chk("arst_read", imem_read, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_read_after", imem_read, 1);
        chk("arst_addr_after", imem_address, PC_RESET);
        chk("directed_sb_empty", sb.size(), 0);

        exp_pc = PC_RESET;
        busy   = 0;
        stale  = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            imem_resp = 1'b0;
            iq_ack    = 1'b0;
            flush     = 1'b0;
            if (busy) chk("read_held", imem_read, 1);
            if (imem_read && !busy) begin
                busy     = 1;
                wait_cnt = $urandom_range(0, 3);
            end
            if (imem_read && !stale) chk("fetch_addr", imem_address, exp_pc);
            do_resp = 0;
            if (busy) begin
                if (wait_cnt == 0) do_resp = 1;
                else wait_cnt--;
            end
            do_flush = ($urandom_range(0, 11) == 0);
            do_ack   = 0;
            iq.issue_q_full_n = ($urandom_range(0, 3) != 0);
            if (iq.ld_iq && iq.issue_q_full_n) do_ack = $urandom_range(0, 1) == 1;
            if (do_resp) begin
                imem_resp  = 1'b1;
                imem_rdata = rand_instr();
                if (!do_flush && !stale) sb.push_back(model(imem_rdata, exp_pc));
                busy  = 0;
                stale = 0;
            end else if (do_flush && busy) begin
                stale = 1;
            end
            if (do_flush) begin
                flush_pc = $urandom() & 32'hFFFF_FFFC;
                exp_pc   = flush_pc;
            end else if (do_ack) begin
                exp_pc = exp_pc + 4;
            end
            flush  = do_flush;
            iq_ack = do_ack;
            @(negedge clk);
        end
        imem_resp = 1'b0;
        iq_ack    = 1'b0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        chk("final_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
